// File: rtl/adder16_slice_sequencer.sv
// adder16_slice_sequencer: builds a WIDTH-bit add with carry-in from NPASS
// passes through one external SLICE-bit adder. Operands are latched on
// acceptance, one slice per cycle is driven out with the carry chained
// through a register, and the partial sums are gathered into an accumulator.
// The (WIDTH+1)-bit result is then held on a valid/ready handshake.
module adder16_slice_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy,
  output logic [SLICE-1:0] sl_a,
  output logic [SLICE-1:0] sl_b,
  output logic             sl_cin,
  input  logic [SLICE-1:0] sl_sum,
  input  logic             sl_cout
);

  localparam int NPASS = (WIDTH + SLICE - 1) / SLICE;
  localparam int PW    = NPASS * SLICE;
  localparam int PCW   = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int IW    = (PW > 1) ? $clog2(PW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [PW-1:0]  op_a;
  logic [PW-1:0]  op_b;
  logic [PW-1:0]  acc;
  logic           carry;
  logic [PCW-1:0] pass;
  logic [IW-1:0]  base;
  logic           accept;
  logic           last_pass;
  logic [PW:0]    result;
  logic           unused_bits;

  assign accept    = in_valid && (state == S_IDLE);
  assign last_pass = (pass == PCW'(NPASS - 1));
  assign base      = IW'(32'(pass) * 32'(SLICE));

  // The carry register sits above the accumulator so that bit WIDTH is the
  // final slice carry when WIDTH is a multiple of SLICE, and the padded top
  // slice's sum bit otherwise.
  assign result      = {carry, acc};
  assign unused_bits = ^result;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: one RUN cycle per pass, DONE holds until consumed.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_RUN;
      S_RUN:   if (last_pass) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, pass counter, carry chain and partial-sum collection.
  // NOTE: the accumulator is an ordinary register, not a memory, so it is
  // reset along with everything else; an aborted add leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      pass  <= '0;
    end else if (accept) begin
      op_a  <= PW'(in_a);
      op_b  <= PW'(in_b);
      acc   <= '0;
      carry <= in_cin;
      pass  <= '0;
    end else if (state == S_RUN) begin
      acc[base +: SLICE] <= sl_sum;
      carry              <= sl_cout;
      pass               <= last_pass ? '0 : pass + PCW'(1);
    end
  end

  // Outputs decoded from registered state: the slice is driven only in RUN,
  // the result only in DONE, so outside those states everything reads zero.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_sum   = '0;
    sl_a      = '0;
    sl_b      = '0;
    sl_cin    = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_RUN: begin
        busy   = 1'b1;
        sl_a   = op_a[base +: SLICE];
        sl_b   = op_b[base +: SLICE];
        sl_cin = carry;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_sum   = result[WIDTH:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_adder16_slice_sequencer.sv
// Bench for adder16_slice_sequencer: a default 16/5 build and a 10/5 build,
// each wired to an exact behavioural slice adder. Accepted requests push the
// expected result (plain integer addition) and the expected per-pass slice
// drive into a scoreboard; monitors on the falling edge compare whatever the
// DUT presents. Timing convention: acceptance on edge T; the pass cycles close
// at edges T+1..T+NPASS and out_valid is high in the cycle closing at
// T+NPASS+1.
module tb_adder16_slice_sequencer;

  localparam int NP  = 4;
  localparam int NPW = 2;

  typedef struct packed {
    logic [16:0] sum;
    logic [19:0] ea;
    logic [19:0] eb;
    logic [3:0]  ec;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_sum;
  logic        busy;
  logic [4:0]  sl_a;
  logic [4:0]  sl_b;
  logic        sl_cin;
  logic [4:0]  sl_sum;
  logic        sl_cout;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [9:0]  w_in_a;
  logic [9:0]  w_in_b;
  logic        w_in_cin;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [10:0] w_out_sum;
  logic        w_busy;
  logic [4:0]  w_sl_a;
  logic [4:0]  w_sl_b;
  logic        w_sl_cin;
  logic [4:0]  w_sl_sum;
  logic        w_sl_cout;

  int          n_tests;
  int          n_fail;
  int          cyc;
  exp_t        q[$];
  int          acc_cycles[$];
  logic [10:0] wq[$];
  bit          exp_busy;
  int          pass_cnt;
  bit          w_exp_busy;
  int          w_cnt;

  adder16_slice_sequencer #(.WIDTH(16), .SLICE(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .busy(busy), .sl_a(sl_a),
    .sl_b(sl_b), .sl_cin(sl_cin), .sl_sum(sl_sum), .sl_cout(sl_cout)
  );

  adder16_slice_sequencer #(.WIDTH(10), .SLICE(5)) dut_w10 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_cin(w_in_cin), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_sum(w_out_sum), .busy(w_busy), .sl_a(w_sl_a),
    .sl_b(w_sl_b), .sl_cin(w_sl_cin), .sl_sum(w_sl_sum), .sl_cout(w_sl_cout)
  );

  // Exact slice adders.
  assign {sl_cout, sl_sum}     = 6'(sl_a) + 6'(sl_b) + 6'(sl_cin);
  assign {w_sl_cout, w_sl_sum} = 6'(w_sl_a) + 6'(w_sl_b) + 6'(w_sl_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected result and per-pass slice drive for a 16-bit add on 5-bit slices.
  function automatic exp_t make_exp(input int unsigned a, input int unsigned b,
                                    input int unsigned cin);
    exp_t        e;
    int unsigned c;
    int unsigned ak;
    int unsigned bk;
    e     = '0;
    e.sum = 17'(a + b + cin);
    c     = cin;
    for (int k = 0; k < NP; k++) begin
      ak             = (a >> (5 * k)) & 32'd31;
      bk             = (b >> (5 * k)) & 32'd31;
      e.ea[k*5 +: 5] = 5'(ak);
      e.eb[k*5 +: 5] = 5'(bk);
      e.ec[k]        = c[0];
      c              = (ak + bk + c) >> 5;
    end
    return e;
  endfunction

  // Scoreboard monitor for the 16-bit instance.
  initial forever begin
    bit   run_now;
    bit   done_now;
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      exp_busy = 1'b0;
      pass_cnt = 0;
    end
    run_now  = exp_busy && (pass_cnt < NP);
    done_now = exp_busy && (pass_cnt == NP);
    check("in_ready", 32'(in_ready), 32'(!exp_busy));
    check("busy", 32'(busy), 32'(exp_busy));
    check("out_valid", 32'(out_valid), 32'(done_now));
    if (run_now) begin
      e = q[0];
      check("slice_drive", 32'({sl_a, sl_b, sl_cin}),
            32'({e.ea[pass_cnt*5 +: 5], e.eb[pass_cnt*5 +: 5], e.ec[pass_cnt]}));
      pass_cnt++;
    end else begin
      check("slice_idle", 32'({sl_a, sl_b, sl_cin}), 32'(0));
    end
    if (done_now) begin
      check("out_sum", 32'(out_sum), 32'(q[0].sum));
      if (out_ready) begin
        void'(q.pop_front());
        exp_busy = 1'b0;
      end
    end
    if (rst_n && in_valid && !run_now && !done_now) begin
      q.push_back(make_exp(32'(in_a), 32'(in_b), 32'(in_cin)));
      acc_cycles.push_back(cyc + 1);
      exp_busy = 1'b1;
      pass_cnt = 0;
    end
  end

  // Scoreboard monitor for the 10-bit instance.
  initial forever begin
    bit run_now;
    bit done_now;
    @(negedge clk);
    if (!rst_n) begin
      wq.delete();
      w_exp_busy = 1'b0;
      w_cnt      = 0;
    end
    run_now  = w_exp_busy && (w_cnt < NPW);
    done_now = w_exp_busy && (w_cnt == NPW);
    check("w_in_ready", 32'(w_in_ready), 32'(!w_exp_busy));
    check("w_out_valid", 32'(w_out_valid), 32'(done_now));
    if (run_now) w_cnt++;
    if (done_now) begin
      check("w_out_sum", 32'(w_out_sum), 32'(wq[0]));
      if (w_out_ready) begin
        void'(wq.pop_front());
        w_exp_busy = 1'b0;
      end
    end
    if (rst_n && w_in_valid && !run_now && !done_now) begin
      wq.push_back(11'(32'(w_in_a) + 32'(w_in_b) + 32'(w_in_cin)));
      w_exp_busy = 1'b1;
      w_cnt      = 0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_in_ready", 32'(in_ready), 32'(1));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_out_valid", 32'(out_valid), 32'(1));
  endtask

  task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input int hold);
    wait_ready();
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble the operand pins: the latched copy must be used.
    in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
    wait_valid();
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_add_w(input logic [9:0] a, input logic [9:0] b, input logic c);
    int n = 0;
    while (!w_in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    w_in_a = a; w_in_b = b; w_in_cin = c; w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    w_in_a = 10'($urandom); w_in_b = 10'($urandom);
    n = 0;
    while (!w_out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("w_wait_out_valid", 32'(w_out_valid), 32'(1));
    w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_cin = 1'b0; w_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({out_valid, busy, out_sum, sl_a, sl_b, sl_cin}), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed adds: mixed slices, full carry ripple, all-ones with carry-in.
    do_add(16'h1234, 16'h4321, 1'b0, 0);
    do_add(16'hFFFF, 16'h0001, 1'b0, 0);
    do_add(16'hFFFF, 16'hFFFF, 1'b1, 1);

    // Back-pressure: result held, requests ignored while DONE.
    wait_ready();
    in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid();
    repeat (10) begin
      in_valid = 1'($urandom); in_a = 16'($urandom); in_b = 16'($urandom);
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(out_valid), 32'(1));
      check("bp_hold_sum", 32'(out_sum), 32'h05555);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'(0));
    check("bp_release_ready", 32'(in_ready), 32'(1));

    // Reset during pass 2 aborts; the next add runs cleanly.
    in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({out_valid, busy, out_sum, sl_a, sl_b, sl_cin}), 32'(0));
    check("abort_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_add(16'h0003, 16'h0004, 1'b0, 0);

    // Streaming with in_valid and out_ready held high: one add per NP+2 cycles.
    acc_cycles.delete();
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (20) begin
      in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    check("stream_accepts", 32'(acc_cycles.size() >= 3), 32'(1));
    for (int i = 1; i < acc_cycles.size(); i++)
      check("stream_spacing", 32'(acc_cycles[i] - acc_cycles[i-1]), 32'(NP + 2));

    // Randomised adds with random consumer stalls.
    for (int i = 0; i < 150; i++) begin
      if (i % 25 == 0)
        do_add(16'hFFFF, 16'($urandom), 1'($urandom), 0);
      else
        do_add(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // 10-bit build: top carry comes straight from the last slice carry.
    do_add_w(10'h3FF, 10'h001, 1'b0);
    do_add_w(10'h3FF, 10'h3FF, 1'b1);
    for (int i = 0; i < 20; i++)
      do_add_w(10'($urandom), 10'($urandom), 1'($urandom));

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 32'(q.size()), 32'(0));
    check("w_sb_drained", 32'(wq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
